retire_trace_ctrl: RTL and testbench



---
 rtl/retire_trace_ctrl_if.sv | 21 ++
 rtl/retire_trace_ctrl.sv | 131 +++++++++++++
 tb/tb_retire_trace_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_ctrl_if.sv
// Trace-record sink port: show-ahead record with valid/ready handshake.
// master drives the record, slave (trace sink) drives ready.
interface retire_trace_ctrl_if;
    logic        trc_vld;
    logic        trc_rdy;
    logic [31:0] trc_pc;
    logic        trc_wb_en;
    logic [4:0]  trc_wb_idx;
    logic [31:0] trc_wb_data;
    logic [31:0] trc_mcause;

    modport master (
        output trc_vld, trc_pc, trc_wb_en, trc_wb_idx, trc_wb_data, trc_mcause,
        input  trc_rdy
    );

    modport slave (
        input  trc_vld, trc_pc, trc_wb_en, trc_wb_idx, trc_wb_data, trc_mcause,
        output trc_rdy
    );
endinterface

// File: rtl/retire_trace_ctrl.sv
// Retire-trace scheduler: pairs each retired instruction with its GPR writeback,
// queues the records in a FIFO and drains them to a trace sink, counting drops.
module retire_trace_ctrl #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WB_LAG = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     retire,
    input  logic [31:0]              retire_pc,
    input  logic                     wb_gpr_en,
    input  logic [4:0]               wb_gpr_index,
    input  logic [31:0]              wb_gpr_data,
    input  logic [31:0]              mcause,
    retire_trace_ctrl_if.master      trc,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf,
    output logic [CNT_W-1:0]         ovf_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e            state_q, state_d;
    logic [31:0]       hold_pc_q, hold_pc_d;
    logic [31:0]       hold_mc_q, hold_mc_d;
    logic              cap, push, pop, wr_en, drop, full, empty;
    logic [101:0]      rec, head;
    logic [101:0]      mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    // Capture FSM; with WB_LAG=0 the record is pushed directly and the FSM idles.
    always_comb begin
        cap       = retire & trace_en;
        state_d   = state_q;
        hold_pc_d = hold_pc_q;
        hold_mc_d = hold_mc_q;
        push      = 1'b0;
        rec       = {retire_pc, wb_gpr_en, wb_gpr_index, wb_gpr_data, mcause};
        if (WB_LAG == 0) begin
            push = cap;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap) begin
                        hold_pc_d = retire_pc;
                        hold_mc_d = mcause;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    push = 1'b1;
                    rec  = {hold_pc_q, wb_gpr_en, wb_gpr_index, wb_gpr_data, hold_mc_q};
                    if (cap) begin
                        hold_pc_d = retire_pc;
                        hold_mc_d = mcause;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_pc_q <= '0;
            hold_mc_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_pc_q <= hold_pc_d;
            hold_mc_q <= hold_mc_d;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && trc.trc_rdy;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= rec;
    end

    assign head            = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign trc.trc_vld     = !empty;
    assign trc.trc_pc      = head[101:70];
    assign trc.trc_wb_en   = head[69];
    assign trc.trc_wb_idx  = head[68:64];
    assign trc.trc_wb_data = head[63:32];
    assign trc.trc_mcause  = head[31:0];

    assign fifo_cnt = wr_ptr_q - rd_ptr_q;
    assign ovf      = ovf_q;
    assign ovf_cnt  = ovf_cnt_q;
endmodule

// File: tb/tb_retire_trace_ctrl.sv
// Bench for retire_trace_ctrl: WB_LAG=0 and WB_LAG=1 instances share stimulus and
// are compared every cycle against a list-based record model plus literal checks.
module tb_retire_trace_ctrl;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, trace_en, retire, wb_gpr_en;
    logic [31:0] retire_pc, wb_gpr_data, mcause;
    logic [4:0]  wb_gpr_index;
    logic [3:0]  cnt0, cnt1;
    logic        ovf0, ovf1;
    logic [15:0] ocnt0;
    logic [2:0]  ocnt1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        chk_en  = 1'b0;

    retire_trace_ctrl_if if0 ();
    retire_trace_ctrl_if if1 ();

    retire_trace_ctrl #(.DEPTH(DEPTH), .WB_LAG(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .trace_en(trace_en), .retire(retire), .retire_pc(retire_pc),
        .wb_gpr_en(wb_gpr_en), .wb_gpr_index(wb_gpr_index), .wb_gpr_data(wb_gpr_data),
        .mcause(mcause), .trc(if0), .fifo_cnt(cnt0), .ovf(ovf0), .ovf_cnt(ocnt0)
    );

    retire_trace_ctrl #(.DEPTH(DEPTH), .WB_LAG(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .trace_en(trace_en), .retire(retire), .retire_pc(retire_pc),
        .wb_gpr_en(wb_gpr_en), .wb_gpr_index(wb_gpr_index), .wb_gpr_data(wb_gpr_data),
        .mcause(mcause), .trc(if1), .fifo_cnt(cnt1), .ovf(ovf1), .ovf_cnt(ocnt1)
    );

    always #5 clk = ~clk;

    // Model: per instance an ordered record list, a pending-retire slot for the
    // lagged instance, and drop bookkeeping.
    logic [101:0] mlist [2][DEPTH+1];
    int unsigned  mcnt  [2] = '{0, 0};
    logic         movf  [2] = '{1'b0, 1'b0};
    int unsigned  mdrop [2] = '{0, 0};
    int unsigned  msat  [2] = '{65535, 7};
    logic         mpend [2] = '{1'b0, 1'b0};
    logic [31:0]  mppc  [2];
    logic [31:0]  mpmc  [2];

    task automatic model_step(input int id, input logic rdy);
        logic         cap, push, pop;
        logic [101:0] rec;
        if (rst) begin
            mcnt[id] = 0; movf[id] = 1'b0; mdrop[id] = 0; mpend[id] = 1'b0;
            return;
        end
        cap = retire && trace_en;
        if (id == 0) begin
            push = cap;
            rec  = {retire_pc, wb_gpr_en, wb_gpr_index, wb_gpr_data, mcause};
        end else begin
            push = mpend[id];
            rec  = {mppc[id], wb_gpr_en, wb_gpr_index, wb_gpr_data, mpmc[id]};
            mpend[id] = cap;
            if (cap) begin
                mppc[id] = retire_pc;
                mpmc[id] = mcause;
            end
        end
        pop = (mcnt[id] != 0) && rdy;
        if (pop) begin
            for (int k = 0; k + 1 < int'(mcnt[id]); k++) mlist[id][k] = mlist[id][k+1];
            mcnt[id]--;
        end
        if (push) begin
            if (mcnt[id] < DEPTH) begin
                mlist[id][mcnt[id]] = rec;
                mcnt[id]++;
            end else begin
                movf[id] = 1'b1;
                if (mdrop[id] < msat[id]) mdrop[id]++;
            end
        end
    endtask

    task automatic chk_model(input int id, input logic [123:0] act);
        logic [101:0] hd;
        logic [123:0] exp;
        hd  = (mcnt[id] != 0) ? mlist[id][0] : '0;
        exp = {mcnt[id] != 0, hd, 4'(mcnt[id]), movf[id], 16'(mdrop[id])};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 20)
                $display("FAIL model%0d @%0t: got {vld,rec,cnt,ovf,ovfcnt}=%h expected %h",
                         id, $time, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, if0.trc_rdy);
        model_step(1, if1.trc_rdy);
        #1;
        if (chk_en) begin
            chk_model(0, {if0.trc_vld, if0.trc_pc, if0.trc_wb_en, if0.trc_wb_idx,
                          if0.trc_wb_data, if0.trc_mcause, cnt0, ovf0, ocnt0});
            chk_model(1, {if1.trc_vld, if1.trc_pc, if1.trc_wb_en, if1.trc_wb_idx,
                          if1.trc_wb_data, if1.trc_mcause, cnt1, ovf1, 16'(ocnt1)});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_rdy(input logic r);
        if0.trc_rdy = r;
        if1.trc_rdy = r;
    endtask

    initial begin
        rst = 1'b1; trace_en = 1'b1; retire = 1'b0; retire_pc = '0; mcause = '0;
        wb_gpr_en = 1'b0; wb_gpr_index = '0; wb_gpr_data = '0;
        set_rdy(1'b0);
        tick(); tick();
        rst = 1'b0; chk_en = 1'b1;
        chk("rst_vld0", 32'(if0.trc_vld), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_ovf1", 32'(ovf1), 0);

        // Single record, immediate writeback
        retire = 1'b1; retire_pc = 32'h8000_0000; wb_gpr_en = 1'b1;
        wb_gpr_index = 5'd5; wb_gpr_data = 32'h1234; mcause = '0;
        tick();
        retire = 1'b0; wb_gpr_en = 1'b0;
        chk("A_vld", 32'(if0.trc_vld), 1);
        chk("A_pc", if0.trc_pc, 32'h8000_0000);
        chk("A_wben", 32'(if0.trc_wb_en), 1);
        chk("A_idx", 32'(if0.trc_wb_idx), 5);
        chk("A_data", if0.trc_wb_data, 32'h1234);
        set_rdy(1'b1); tick();
        chk("A_cnt_after_pop", 32'(cnt0), 0);
        tick(); set_rdy(1'b0); tick();

        // Lagged writeback pairing
        retire = 1'b1; retire_pc = 32'h100; wb_gpr_en = 1'b0;
        tick();
        retire_pc = 32'h104; wb_gpr_en = 1'b1; wb_gpr_index = 5'd3; wb_gpr_data = 32'hAB;
        tick();
        retire = 1'b0; wb_gpr_index = 5'd7; wb_gpr_data = 32'hCD;
        tick();
        wb_gpr_en = 1'b0;
        tick();
        chk("B_cnt1", 32'(cnt1), 2);
        chk("B_pc1_0", if1.trc_pc, 32'h100);
        chk("B_idx1_0", 32'(if1.trc_wb_idx), 3);
        chk("B_data1_0", if1.trc_wb_data, 32'hAB);
        set_rdy(1'b1); tick(); set_rdy(1'b0);
        chk("B_pc1_1", if1.trc_pc, 32'h104);
        chk("B_wben1_1", 32'(if1.trc_wb_en), 1);
        chk("B_idx1_1", 32'(if1.trc_wb_idx), 7);
        chk("B_data1_1", if1.trc_wb_data, 32'hCD);
        set_rdy(1'b1); tick(); tick(); set_rdy(1'b0);

        // Overflow: 10 back-to-back retires into an 8-deep FIFO
        for (int i = 0; i < 10; i++) begin
            retire = 1'b1; retire_pc = 32'h1000 + 32'(4 * i);
            wb_gpr_en = i[0]; wb_gpr_data = 32'(i);
            tick();
        end
        retire = 1'b0;
        tick();
        chk("C_cnt0", 32'(cnt0), 8);
        chk("C_ovf0", 32'(ovf0), 1);
        chk("C_ocnt0", 32'(ocnt0), 2);
        chk("C_cnt1", 32'(cnt1), 8);
        chk("C_ocnt1", 32'(ocnt1), 2);

        // Full FIFO with simultaneous push and pop
        retire = 1'b1; retire_pc = 32'h2000; set_rdy(1'b1);
        tick();
        retire = 1'b0; set_rdy(1'b0);
        chk("D_cnt0", 32'(cnt0), 8);
        chk("D_ocnt0", 32'(ocnt0), 2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("D_drain%0d", i), if0.trc_pc,
                (i < 7) ? 32'h1000 + 32'(4 * (i + 1)) : 32'h2000);
            set_rdy(1'b1);
            tick();
        end
        set_rdy(1'b0);

        // Capture disabled, then a pending hold across trace_en falling
        trace_en = 1'b0; retire = 1'b1;
        tick(); tick(); tick();
        retire = 1'b0;
        tick();
        chk("E_cnt0_off", 32'(cnt0), 0);
        chk("E_cnt1_off", 32'(cnt1), 0);
        trace_en = 1'b1; retire = 1'b1; retire_pc = 32'h300;
        tick();
        trace_en = 1'b0; retire_pc = 32'h304;
        tick();
        retire = 1'b0;
        tick();
        chk("E_cnt1_hold", 32'(cnt1), 1);
        chk("E_pc1_hold", if1.trc_pc, 32'h300);
        chk("E_cnt0", 32'(cnt0), 1);
        trace_en = 1'b1;

        // Reset with records queued
        for (int i = 0; i < 5; i++) begin
            retire = 1'b1; retire_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        retire = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("F_vld0", 32'(if0.trc_vld), 0);
        chk("F_cnt0", 32'(cnt0), 0);
        chk("F_ocnt0", 32'(ocnt0), 0);
        chk("F_ovf0", 32'(ovf0), 0);
        chk("F_vld1", 32'(if1.trc_vld), 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            trace_en     = ($urandom_range(0, 9) != 0);
            retire       = ($urandom_range(0, 4) < 3);
            retire_pc    = $urandom;
            mcause       = $urandom;
            wb_gpr_en    = $urandom_range(0, 1) == 1;
            wb_gpr_index = 5'($urandom);
            wb_gpr_data  = $urandom;
            set_rdy($urandom_range(0, 1) == 1);
            tick();
        end

        // Heavy backpressure without reset drives the 3-bit drop counter to saturation
        rst = 1'b0; trace_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            retire    = ($urandom_range(0, 4) < 3);
            retire_pc = $urandom;
            set_rdy($urandom_range(0, 9) == 0);
            tick();
        end
        retire = 1'b0; set_rdy(1'b0);
        tick();
        chk("G_sat_ocnt1", 32'(ocnt1), 7);
        chk("G_sat_ovf1", 32'(ovf1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
